pipe_ctrl: RTL and testbench

- Central pipeline sequencing controller for the five-stage core (IF/ID/EX/MEM/WB).
- Merges stall requests from ID (operand hazard) and EX (multi-cycle op) into a per-stage stall vector.
- Sequences a multi-cycle flush with redirect PC.
- Tracks consecutive-stall duration with a watchdog flag and keeps a free-running stall performance count.

---
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Five-stage pipeline sequencing controller: stall merge, flush
//             sequencing with redirect PC, stall watchdog and stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int MAX_STALL = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             stall_timeout_o,
    output logic [31:0]      stall_total_o
);

    localparam int              FC_W         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] C_FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] C_MAX       = CNT_W'(MAX_STALL);
    localparam logic [5:0]      C_STALL_EX   = 6'b001111;
    localparam logic [5:0]      C_STALL_ID   = 6'b000111;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [FC_W-1:0]  fcnt_q,  fcnt_d;
    logic [31:0]      pc_q,    pc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             to_q,    to_d;
    logic [31:0]      total_q, total_d;
    logic [5:0]       w_stall;
    logic [CNT_W-1:0] w_cnt_inc;

    // Reset is folded in so the stall vector reads zero while rst is low.
    always_comb begin
        w_stall = 6'b000000;
        if (rst && (state_q == S_RUN)) begin
            if (stallreq_ex) begin
                w_stall = C_STALL_EX;
            end else if (stallreq_id) begin
                w_stall = C_STALL_ID;
            end
        end
    end

    assign w_cnt_inc = (cnt_q == C_MAX) ? C_MAX : (cnt_q + 1'b1);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        total_d = total_q;
        case (state_q)
            S_RUN: begin
                if (w_stall != 6'b000000) begin
                    total_d = total_q + 32'd1;
                    cnt_d   = w_cnt_inc;
                    to_d    = to_q | (w_cnt_inc == C_MAX);
                end else begin
                    cnt_d   = '0;
                end
                // Flush entry overrides the watchdog update of this same edge.
                if (flush_req) begin
                    state_d = S_FLUSH;
                    fcnt_d  = C_FLUSH_LAST;
                    pc_d    = flush_pc;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            S_FLUSH: begin
                cnt_d = '0;
                to_d  = 1'b0;
                if (fcnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            fcnt_q  <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            total_q <= total_d;
        end
    end

    assign stall_o         = w_stall;
    assign flush_o         = (state_q == S_FLUSH);
    assign new_pc_o        = pc_q;
    assign stall_cnt_o     = cnt_q;
    assign stall_timeout_o = to_q;
    assign stall_total_o   = total_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Brief    : Self-checking bench for pipe_ctrl against a cycle-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int FLUSH_CYC = 2;
    localparam int MAX_STALL = 4;
    localparam int CNT_W     = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             stallreq_id = 1'b0;
    logic             stallreq_ex = 1'b0;
    logic             flush_req = 1'b0;
    logic [31:0]      flush_pc = '0;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             stall_timeout_o;
    logic [31:0]      stall_total_o;

    int checks   = 0;
    int failures = 0;

    // Model: remaining flush cycles (0 = running), latched PC, counters.
    int          m_flush_left;
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_to;
    logic [31:0] m_total;

    pipe_ctrl #(.FLUSH_CYC(FLUSH_CYC), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_id     (stallreq_id),
        .stallreq_ex     (stallreq_ex),
        .flush_req       (flush_req),
        .flush_pc        (flush_pc),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .stall_cnt_o     (stall_cnt_o),
        .stall_timeout_o (stall_timeout_o),
        .stall_total_o   (stall_total_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_pc         = '0;
        m_cnt        = 0;
        m_to         = 1'b0;
        m_total      = '0;
    endtask

    function automatic logic [5:0] exp_stall();
        if (m_flush_left > 0) return 6'b000000;
        if (stallreq_ex)      return 6'b001111;
        if (stallreq_id)      return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".stall"},   32'(stall_o),         32'(exp_stall()));
        chk({tag, ".flush"},   32'(flush_o),         32'(m_flush_left > 0));
        chk({tag, ".new_pc"},  new_pc_o,             m_pc);
        chk({tag, ".cnt"},     32'(stall_cnt_o),     32'(m_cnt));
        chk({tag, ".timeout"}, 32'(stall_timeout_o), 32'(m_to));
        chk({tag, ".total"},   stall_total_o,        m_total);
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        if (m_flush_left > 0) begin
            m_flush_left--;
            m_cnt = 0;
            m_to  = 1'b0;
        end else begin
            if (exp_stall() != 6'b000000) begin
                m_total++;
                m_cnt = (m_cnt + 1 > MAX_STALL) ? MAX_STALL : m_cnt + 1;
                if (m_cnt == MAX_STALL) m_to = 1'b1;
            end else begin
                m_cnt = 0;
            end
            if (flush_req) begin
                m_flush_left = FLUSH_CYC;
                m_pc         = flush_pc;
                m_cnt        = 0;
                m_to         = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, compare before the edge, return 1ns after it.
    task automatic cyc(input bit id, input bit ex, input bit fr, input logic [31:0] pc);
        @(negedge clk);
        stallreq_id = id;
        stallreq_ex = ex;
        flush_req   = fr;
        flush_pc    = pc;
        #1;
        compare_all("cyc");
        model_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] saved_total;
    int          exp_cnt_seq [6] = '{1, 2, 3, 4, 4, 4};

    initial begin
        model_reset();
        // Reset held with a request active: every output must read zero.
        stallreq_id = 1'b1;
        #1;
        chk("reset.stall",   32'(stall_o),         32'h0);
        chk("reset.flush",   32'(flush_o),         32'h0);
        chk("reset.new_pc",  new_pc_o,             32'h0);
        chk("reset.cnt",     32'(stall_cnt_o),     32'h0);
        chk("reset.timeout", 32'(stall_timeout_o), 32'h0);
        chk("reset.total",   stall_total_o,        32'h0);
        @(negedge clk);
        @(negedge clk);
        stallreq_id = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("idle.total", stall_total_o, 32'd0);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            chk("id.stall", 32'(stall_o),     32'h07);
            chk("id.cnt",   32'(stall_cnt_o), 32'(i + 1));
        end
        chk("id.total", stall_total_o, 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("both.stall", 32'(stall_o), 32'h0F);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("drop.cnt",   32'(stall_cnt_o), 32'd0);
        chk("drop.total", stall_total_o,    32'd4);

        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        chk("fl1.flush",  32'(flush_o), 32'd1);
        chk("fl1.new_pc", new_pc_o,     32'h100);
        cyc(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("fl2.flush",  32'(flush_o), 32'd1);
        chk("fl2.stall",  32'(stall_o), 32'h0);
        chk("fl2.new_pc", new_pc_o,     32'h100);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("fl3.flush",  32'(flush_o), 32'd0);
        chk("fl3.new_pc", new_pc_o,     32'h100);

        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            chk("wd.cnt", 32'(stall_cnt_o), 32'(exp_cnt_seq[i]));
            chk("wd.timeout", 32'(stall_timeout_o), 32'(i >= 3));
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wd.sticky", 32'(stall_timeout_o), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_2000);
        chk("wd.clear", 32'(stall_timeout_o), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        saved_total = stall_total_o;
        cyc(1'b1, 1'b0, 1'b1, 32'hBFC0_0000);
        chk("sim.flush",  32'(flush_o),     32'd1);
        chk("sim.new_pc", new_pc_o,         32'hBFC0_0000);
        chk("sim.cnt",    32'(stall_cnt_o), 32'd0);
        chk("sim.total",  stall_total_o,    saved_total + 32'd1);

        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("arst.pre", 32'(flush_o), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst.flush",  32'(flush_o), 32'd0);
        chk("arst.new_pc", new_pc_o,     32'h0);
        chk("arst.total",  stall_total_o, 32'h0);
        model_reset();
        #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("arst.run", 32'(stall_o), 32'h07);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0), $urandom);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
